kbd_ascii: RTL and testbench
============================

// Module: kbd_ascii
// PURPOSE
//  Downstream stage of the PS/2 receiver: consumes raw set-2 scancode bytes, decodes
//  prefixes (E0/F0) and modifiers, translates make codes to 7-bit ASCII and buffers the
//  characters in a FIFO. Exposes a KL11-style keyboard receiver (CSR + data) on Wishbone
//  with its own interrupt request, so the CPU sees characters instead of scancodes.
// PARAMETERS
//  FIFO_AW   3   log2 of FIFO depth (depth = 2**FIFO_AW = 8 characters)
// PORTS
//  wb_clk_i    in   1   bus clock, the only clock
//  wb_rst_i    in   1   reset, synchronous, active-high
//  wb_adr_i    in   16  address; only [1] decoded (0=CSR, 1=data)
//  wb_dat_i    in   16  write data
//  wb_dat_o    out  16  read data, registered
//  wb_cyc_i    in   1   bus cycle
//  wb_we_i     in   1   1=write, 0=read
//  wb_stb_i    in   1   strobe
//  wb_sel_i    in   2   byte selects
//  wb_ack_o    out  1   acknowledge
//  irq         out  1   interrupt request
//  iack        in   1   interrupt acknowledge
//  scan_data   in   8   scancode byte from PS/2 receiver
//  scan_valid  in   1   one-cycle pulse: scan_data valid
// BEHAVIOUR
//  Reset: wb_ack_o=0, wb_dat_o=0, irq=0, IE=0, OVR=0, FIFO empty, prefix FSM=IDLE,
//   shift/ctrl/caps/caps_held all 0.
//  Bus: ack <= cyc&stb&~ack (one wait state, 1-cycle ack). Side effects only on cycles
//   where cyc&stb&~ack, so each transaction acts exactly once.
//  CSR (adr[1]=0) read: {OVR,7'b0,DONE,IE,6'b0}; DONE = FIFO non-empty; read clears OVR.
//  CSR write: if wb_sel_i[0], IE <= wb_dat_i[6]; other bits ignored.
//  Data (adr[1]=1) read: non-empty -> {9'b0,head char}, pop; empty -> 16'h0000, no pop.
//   Data writes ignored.
//  Prefix FSM (advances on scan_valid only):
//   IDLE: E0->EXT, F0->BRK, else make(code,ext=0)
//   EXT:  F0->EXTBRK, else make(code,ext=1)->IDLE
//   BRK:  break(code,ext=0)->IDLE;  EXTBRK: break(code,ext=1)->IDLE
//   E1 (Pause) and AA/FA/FE/EE (status bytes) in IDLE are discarded, state stays IDLE.
//  Modifiers: 12/59 make/break set/clear shift; 14 or E0 14 set/clear ctrl;
//   58 make toggles caps only if caps_held=0, then caps_held=1; 58 break clears caps_held.
//   Modifier keys push nothing.
//  Translation (make only, ext=0 unless stated): letters -> 'a'..'z', upper when
//   shift^caps; digit row 16,1E,26,25,2E,36,3D,3E,46,45 -> '1'..'9','0', with shift
//   -> '!@#$%^&*()'; punctuation per US layout with shift variants; 29->040, 0D->011,
//   5A or E0 5A ->015, 66->177, 76->033, E0 4A->'/'. All other codes (incl. other E0
//   keys, F-keys) push nothing. Breaks of non-modifier keys push nothing.
//  Push occurs in the cycle after the completing scancode byte (1-cycle latency).
//  FIFO: push when full -> char dropped, OVR <= 1. Simultaneous push and pop -> both
//   done, count unchanged. Pointers wrap modulo depth.
//  irq: set when IE & DONE & ~irq & ~iack; cleared when iack=1 (iack wins). Re-asserts
//   next cycle after iack drops if still IE & DONE. Clearing IE does not drop a pending irq.
//  Reset mid-sequence (e.g. after E0/F0): FSM returns to IDLE, partial sequence lost.
// CONFIGURATION
//  KBD_CTRL_EN defined: while ctrl=1, any translated char in 100..177 (octal) is pushed
//   as char & 037 (e.g. ctrl+C -> 003); other chars unchanged.
//  KBD_CTRL_EN undefined: ctrl tracked but has no effect on pushed characters.
// TESTING
//  1 feed 1C -> DONE=1; data read returns 0x0061, then DONE=0; next data read 0x0000.
//  2 feed 12,1C,F0,1C,F0,12,1C -> FIFO holds 'A','a'; caps make 58,58,F0,58 then 1C
//    -> 'A' (caps toggled once despite repeat).
//  3 feed 9 make codes 1C with no reads -> 8 chars, OVR=1 (CSR=0x8080 with IE=0); CSR
//    read clears OVR.
//  4 IE=1, feed 5A -> irq=1 within 2 cycles; iack pulse -> irq=0; pop 015 -> irq stays 0.
//  5 feed E0,75 (up arrow), E0,F0,75 then E0,5A -> only 015 pushed; E0 then reset,
//    then 1C -> 'a'.
//  6 KBD_CTRL_EN: feed 14,21 -> 003; without macro -> 'c'. Push and pop same cycle
//    with FIFO at 3 -> stays 3.

Source files
------------

// File: rtl/kbd_ascii_if.sv
// kbd_ascii_if: Wishbone slave bus bundle for the keyboard receiver.
//   wb_adr_i  16  address (only bit 1 decoded by the slave)
//   wb_dat_i  16  write data
//   wb_dat_o  16  registered read data
//   wb_cyc_i   1  bus cycle
//   wb_we_i    1  1 = write, 0 = read
//   wb_stb_i   1  strobe
//   wb_sel_i   2  byte selects
//   wb_ack_o   1  acknowledge
// The master modport drives the request side; the slave modport answers.
interface kbd_ascii_if;
    logic [15:0] wb_adr_i;
    logic [15:0] wb_dat_i;
    logic [15:0] wb_dat_o;
    logic        wb_cyc_i;
    logic        wb_we_i;
    logic        wb_stb_i;
    logic [1:0]  wb_sel_i;
    logic        wb_ack_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_cyc_i, wb_we_i, wb_stb_i, wb_sel_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_cyc_i, wb_we_i, wb_stb_i, wb_sel_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/kbd_ascii.sv
// kbd_ascii: PS/2 set-2 scancode to ASCII translator with a character FIFO and a
// KL11-style keyboard receiver (CSR + data register) on Wishbone.
//   wb_clk_i     in   1   bus clock (only clock)
//   wb_rst_i     in   1   synchronous active-high reset
//   bus          slave    Wishbone bundle (kbd_ascii_if): adr[1] 0=CSR, 1=data
//   irq          out  1   interrupt request (IE & DONE), cleared by iack
//   iack         in   1   interrupt acknowledge
//   scan_data    in   8   scancode byte from the PS/2 receiver
//   scan_valid   in   1   one-cycle strobe qualifying scan_data
// CSR read = {OVR,7'b0,DONE,IE,6'b0}; reading it clears OVR.
// Data read pops the head character (0x0000 when empty).
// Optional feature macro: KBD_CTRL_EN -- with ctrl held, characters 0x40..0x7F
// are pushed as char & 0x1F.
module kbd_ascii #(
    parameter int unsigned FIFO_AW = 3
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    kbd_ascii_if.slave  bus,
    output logic        irq,
    input  logic        iack,
    input  logic [7:0]  scan_data,
    input  logic        scan_valid
);
    localparam int unsigned DEPTH = 1 << FIFO_AW;

    typedef logic [FIFO_AW-1:0] ptr_t;
    typedef logic [FIFO_AW:0]   cnt_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXTBRK
    } pfx_t;

    pfx_t state, state_nxt;

    logic ev_make, ev_break, ev_ext;
    logic shift, ctrl, caps, caps_held;

    logic [7:0] lc, lo, hi;
    logic       letter, upper, t_valid, do_push;
    logic [6:0] t_char;

    logic [6:0] mem [DEPTH];
    ptr_t       wr_ptr, rd_ptr;
    cnt_t       count;
    logic       done, full, push_ok, ovf;
    logic       access, rd_csr, rd_data, wr_csr, pop;
    logic       ie, ovr;

    // ---------------- Prefix FSM ----------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Emits a one-cycle make/break event when a scancode sequence completes.
    always_comb begin
        state_nxt = state;
        ev_make   = 1'b0;
        ev_break  = 1'b0;
        ev_ext    = 1'b0;
        if (scan_valid) begin
            case (state)
                S_IDLE: begin
                    case (scan_data)
                        8'hE0: state_nxt = S_EXT;
                        8'hF0: state_nxt = S_BRK;
                        8'hE1, 8'hAA, 8'hFA, 8'hFE, 8'hEE: state_nxt = S_IDLE;
                        default: ev_make = 1'b1;
                    endcase
                end
                S_EXT: begin
                    if (scan_data == 8'hF0) begin
                        state_nxt = S_EXTBRK;
                    end else begin
                        ev_make   = 1'b1;
                        ev_ext    = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end
                S_BRK: begin
                    ev_break  = 1'b1;
                    state_nxt = S_IDLE;
                end
                S_EXTBRK: begin
                    ev_break  = 1'b1;
                    ev_ext    = 1'b1;
                    state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // ---------------- Modifier state ----------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            shift     <= 1'b0;
            ctrl      <= 1'b0;
            caps      <= 1'b0;
            caps_held <= 1'b0;
        end else if (ev_make || ev_break) begin
            if (!ev_ext && (scan_data == 8'h12 || scan_data == 8'h59))
                shift <= ev_make;
            if (scan_data == 8'h14)
                ctrl <= ev_make;
            if (!ev_ext && scan_data == 8'h58) begin
                // Typematic repeat of caps lock must not toggle again.
                if (ev_make) begin
                    if (!caps_held) caps <= ~caps;
                    caps_held <= 1'b1;
                end else begin
                    caps_held <= 1'b0;
                end
            end
        end
    end

    // ---------------- Translation ----------------
    always_comb begin
        lc = '0;
        case (scan_data)
            8'h1C: lc = "a";  8'h32: lc = "b";  8'h21: lc = "c";  8'h23: lc = "d";
            8'h24: lc = "e";  8'h2B: lc = "f";  8'h34: lc = "g";  8'h33: lc = "h";
            8'h43: lc = "i";  8'h3B: lc = "j";  8'h42: lc = "k";  8'h4B: lc = "l";
            8'h3A: lc = "m";  8'h31: lc = "n";  8'h44: lc = "o";  8'h4D: lc = "p";
            8'h15: lc = "q";  8'h2D: lc = "r";  8'h1B: lc = "s";  8'h2C: lc = "t";
            8'h3C: lc = "u";  8'h2A: lc = "v";  8'h1D: lc = "w";  8'h22: lc = "x";
            8'h35: lc = "y";  8'h1A: lc = "z";
            default: lc = '0;
        endcase

        letter = (lc != 8'h00) && !ev_ext;
        lo = '0;
        hi = '0;
        if (ev_ext) begin
            case (scan_data)
                8'h4A: begin lo = "/";   hi = "/";   end
                8'h5A: begin lo = 8'h0D; hi = 8'h0D; end
                default: ;
            endcase
        end else if (letter) begin
            lo = lc;
            hi = lc - 8'h20;
        end else begin
            case (scan_data)
                8'h16: begin lo = "1"; hi = "!"; end
                8'h1E: begin lo = "2"; hi = "@"; end
                8'h26: begin lo = "3"; hi = "#"; end
                8'h25: begin lo = "4"; hi = "$"; end
                8'h2E: begin lo = "5"; hi = "%"; end
                8'h36: begin lo = "6"; hi = "^"; end
                8'h3D: begin lo = "7"; hi = "&"; end
                8'h3E: begin lo = "8"; hi = "*"; end
                8'h46: begin lo = "9"; hi = "("; end
                8'h45: begin lo = "0"; hi = ")"; end
                8'h0E: begin lo = 8'h60; hi = 8'h7E; end  // grave / tilde
                8'h4E: begin lo = "-"; hi = "_"; end
                8'h55: begin lo = "="; hi = "+"; end
                8'h54: begin lo = "["; hi = "{"; end
                8'h5B: begin lo = "]"; hi = "}"; end
                8'h5D: begin lo = 8'h5C; hi = "|"; end    // backslash
                8'h4C: begin lo = ";"; hi = ":"; end
                8'h52: begin lo = "'"; hi = 8'h22; end    // double quote
                8'h41: begin lo = ","; hi = "<"; end
                8'h49: begin lo = "."; hi = ">"; end
                8'h4A: begin lo = "/"; hi = "?"; end
                8'h29: begin lo = " "; hi = " "; end
                8'h0D: begin lo = 8'h09; hi = 8'h09; end
                8'h5A: begin lo = 8'h0D; hi = 8'h0D; end
                8'h66: begin lo = 8'h7F; hi = 8'h7F; end
                8'h76: begin lo = 8'h1B; hi = 8'h1B; end
                default: ;
            endcase
        end

        t_valid = (lo != 8'h00);
        upper   = letter ? (shift ^ caps) : shift;
        t_char  = upper ? hi[6:0] : lo[6:0];
`ifdef KBD_CTRL_EN
        if (ctrl && t_char[6]) t_char = {2'b00, t_char[4:0]};
`endif
    end

    assign do_push = ev_make && t_valid;

    // ---------------- Bus decode and FIFO ----------------
    assign done    = (count != '0);
    assign full    = (count == cnt_t'(DEPTH));
    assign access  = bus.wb_cyc_i && bus.wb_stb_i && !bus.wb_ack_o;
    assign rd_csr  = access && !bus.wb_we_i && !bus.wb_adr_i[1];
    assign rd_data = access && !bus.wb_we_i &&  bus.wb_adr_i[1];
    assign wr_csr  = access &&  bus.wb_we_i && !bus.wb_adr_i[1] && bus.wb_sel_i[0];
    assign pop     = rd_data && done;
    // Fullness is judged before any same-cycle pop: a push into a full FIFO drops.
    assign push_ok = do_push && !full;
    assign ovf     = do_push &&  full;

    always_ff @(posedge wb_clk_i) begin
        if (push_ok) mem[wr_ptr] <= t_char;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            bus.wb_ack_o <= 1'b0;
            bus.wb_dat_o <= '0;
            ie           <= 1'b0;
            ovr          <= 1'b0;
            irq          <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
        end else begin
            bus.wb_ack_o <= bus.wb_cyc_i && bus.wb_stb_i && !bus.wb_ack_o;

            if (rd_csr)
                bus.wb_dat_o <= {ovr, 7'b0, done, ie, 6'b0};
            else if (rd_data)
                bus.wb_dat_o <= done ? {9'b0, mem[rd_ptr]} : '0;

            if (wr_csr) ie <= bus.wb_dat_i[6];

            if (ovf)         ovr <= 1'b1;
            else if (rd_csr) ovr <= 1'b0;

            if (push_ok) wr_ptr <= wr_ptr + ptr_t'(1);
            if (pop)     rd_ptr <= rd_ptr + ptr_t'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + cnt_t'(1);
                2'b01:   count <= count - cnt_t'(1);
                default: count <= count;
            endcase

            if (iack)                  irq <= 1'b0;
            else if (ie && done && !irq) irq <= 1'b1;
        end
    end

    logic unused_bits;
`ifdef KBD_CTRL_EN
    assign unused_bits = ^{bus.wb_adr_i[15:2], bus.wb_adr_i[0], bus.wb_dat_i[15:7],
                           bus.wb_dat_i[5:0], bus.wb_sel_i[1], lo[7], hi[7]};
`else
    assign unused_bits = ^{bus.wb_adr_i[15:2], bus.wb_adr_i[0], bus.wb_dat_i[15:7],
                           bus.wb_dat_i[5:0], bus.wb_sel_i[1], lo[7], hi[7], ctrl};
`endif
endmodule

// File: tb/tb_kbd_ascii.sv
// tb_kbd_ascii: directed and randomized checks of kbd_ascii against a
// behavioural model (character queue plus keyboard state flags).
module tb_kbd_ascii;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iack = 1'b0;
    logic        irq;
    logic [7:0]  scan_data = '0;
    logic        scan_valid = 1'b0;

    kbd_ascii_if bus ();

    kbd_ascii #(.FIFO_AW(3)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .bus        (bus),
        .irq        (irq),
        .iack       (iack),
        .scan_data  (scan_data),
        .scan_valid (scan_valid)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- Translation tables ----------------
    logic [7:0] lo_tab [256];
    logic [7:0] hi_tab [256];
    logic       let_tab [256];

    initial begin
        logic [7:0] lcodes [26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,
                                    8'h3B,8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,
                                    8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
        logic [7:0] dcodes [10] = '{8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46,8'h45};
        logic [7:0] pcodes [10] = '{8'h4E,8'h55,8'h54,8'h5B,8'h5D,8'h4C,8'h52,8'h41,8'h49,8'h4A};
        string dlo = "1234567890";
        string dhi = "!@#$%^&*()";
        logic [7:0] plo [10] = '{8'h2D,8'h3D,8'h5B,8'h5D,8'h5C,8'h3B,8'h27,8'h2C,8'h2E,8'h2F};
        logic [7:0] phi [10] = '{8'h5F,8'h2B,8'h7B,8'h7D,8'h7C,8'h3A,8'h22,8'h3C,8'h3E,8'h3F};
        for (int i = 0; i < 256; i++) begin
            lo_tab[i] = 8'h00; hi_tab[i] = 8'h00; let_tab[i] = 1'b0;
        end
        for (int i = 0; i < 26; i++) begin
            lo_tab[lcodes[i]] = 8'h61 + 8'(i);
            hi_tab[lcodes[i]] = 8'h41 + 8'(i);
            let_tab[lcodes[i]] = 1'b1;
        end
        for (int i = 0; i < 10; i++) begin
            lo_tab[dcodes[i]] = dlo[i]; hi_tab[dcodes[i]] = dhi[i];
            lo_tab[pcodes[i]] = plo[i]; hi_tab[pcodes[i]] = phi[i];
        end
        lo_tab[8'h0E] = 8'h60; hi_tab[8'h0E] = 8'h7E;
        lo_tab[8'h29] = 8'h20; hi_tab[8'h29] = 8'h20;
        lo_tab[8'h0D] = 8'h09; hi_tab[8'h0D] = 8'h09;
        lo_tab[8'h5A] = 8'h0D; hi_tab[8'h5A] = 8'h0D;
        lo_tab[8'h66] = 8'h7F; hi_tab[8'h66] = 8'h7F;
        lo_tab[8'h76] = 8'h1B; hi_tab[8'h76] = 8'h1B;
    end

    // ---------------- Behavioural model ----------------
    logic [7:0]  m_q [$];
    logic        m_ack, m_irq, m_ie, m_ovr;
    logic [15:0] m_dat;
    logic        m_ext, m_brk, m_shift, m_ctrl, m_caps, m_held;

    task automatic model_scan(input logic [7:0] b, output logic push, output logic [7:0] ch);
        logic is_make, is_brk, ext, up;
        push = 1'b0; ch = 8'h00; is_make = 1'b0; is_brk = 1'b0; ext = m_ext;
        if (m_brk) begin
            is_brk = 1'b1; m_brk = 1'b0; m_ext = 1'b0;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (m_ext) begin
            is_make = 1'b1; m_ext = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (!(b inside {8'hE1, 8'hAA, 8'hFA, 8'hFE, 8'hEE})) begin
            is_make = 1'b1;
        end

        if (is_make) begin
            if (ext) begin
                if (b == 8'h4A) ch = 8'h2F;
                else if (b == 8'h5A) ch = 8'h0D;
            end else if (lo_tab[b] != 8'h00) begin
                up = let_tab[b] ? (m_shift ^ m_caps) : m_shift;
                ch = up ? hi_tab[b] : lo_tab[b];
            end
`ifdef KBD_CTRL_EN
            if (m_ctrl && ch >= 8'h40) ch = ch & 8'h1F;
`endif
            push = (ch != 8'h00);
        end

        if (is_make || is_brk) begin
            if (!ext && (b == 8'h12 || b == 8'h59)) m_shift = is_make;
            if (b == 8'h14) m_ctrl = is_make;
            if (!ext && b == 8'h58) begin
                if (is_make) begin
                    if (!m_held) m_caps = !m_caps;
                    m_held = 1'b1;
                end else begin
                    m_held = 1'b0;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        logic done, access, pop, push, full_pre, ovr_set, ovr_clr, new_ie;
        logic [7:0] ch;
        if (rst) begin
            m_q.delete();
            m_ack = 0; m_dat = '0; m_irq = 0; m_ie = 0; m_ovr = 0;
            m_ext = 0; m_brk = 0; m_shift = 0; m_ctrl = 0; m_caps = 0; m_held = 0;
        end else begin
            done = (m_q.size() != 0);
            full_pre = (m_q.size() == 8);
            access = bus.wb_cyc_i && bus.wb_stb_i && !m_ack;
            pop = 0; ovr_set = 0; ovr_clr = 0; push = 0; ch = 8'h00;
            if (access && !bus.wb_we_i) begin
                if (!bus.wb_adr_i[1]) begin
                    m_dat = {m_ovr, 7'b0, done, m_ie, 6'b0};
                    ovr_clr = 1;
                end else if (done) begin
                    m_dat = {9'b0, m_q[0][6:0]};
                    pop = 1;
                end else begin
                    m_dat = '0;
                end
            end
            new_ie = m_ie;
            if (access && bus.wb_we_i && !bus.wb_adr_i[1] && bus.wb_sel_i[0])
                new_ie = bus.wb_dat_i[6];
            if (iack) m_irq = 0;
            else if (m_ie && done && !m_irq) m_irq = 1;
            m_ie = new_ie;
            if (scan_valid) model_scan(scan_data, push, ch);
            if (pop) void'(m_q.pop_front());
            if (push) begin
                if (full_pre) ovr_set = 1;
                else m_q.push_back(ch);
            end
            if (ovr_set) m_ovr = 1;
            else if (ovr_clr) m_ovr = 0;
            m_ack = bus.wb_cyc_i && bus.wb_stb_i && !m_ack;
        end
    end

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        check("ack", {15'b0, bus.wb_ack_o}, {15'b0, m_ack});
        check("dat_o", bus.wb_dat_o, m_dat);
        check("irq", {15'b0, irq}, {15'b0, m_irq});
    end

    // ---------------- Stimulus helpers ----------------
    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic feed(input logic [7:0] b);
        @(negedge clk); scan_valid = 1'b1; scan_data = b;
        @(negedge clk); scan_valid = 1'b0;
    endtask

    task automatic bus_xfer(input logic we, input logic a1, input logic [15:0] wd,
                            output logic [15:0] rd);
        logic ok = 1'b0;
        @(negedge clk);
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = we;
        bus.wb_adr_i = {14'b0, a1, 1'b0}; bus.wb_dat_i = wd; bus.wb_sel_i = 2'b11;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.wb_ack_o) begin ok = 1'b1; break; end
        end
        rd = bus.wb_dat_o;
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
        check("ack_timeout", {15'b0, ok}, 16'h0001);
    endtask

    task automatic rd_expect(input string name, input logic a1, input logic [15:0] exp);
        logic [15:0] d;
        bus_xfer(1'b0, a1, 16'h0, d);
        check(name, d, exp);
    endtask

    // ---------------- Test sequence ----------------
    initial begin
        logic [15:0] d;
        logic [7:0] pool [28] = '{8'hE0,8'hF0,8'h12,8'h59,8'h14,8'h58,8'h1C,8'h32,8'h21,8'h16,
                                  8'h45,8'h4E,8'h55,8'h4A,8'h5A,8'h29,8'h0D,8'h66,8'h76,8'h75,
                                  8'h0E,8'h52,8'h5D,8'hE1,8'hAA,8'hFA,8'h05,8'h1A};
        bus.wb_adr_i = '0; bus.wb_dat_i = '0; bus.wb_cyc_i = 0; bus.wb_stb_i = 0;
        bus.wb_we_i = 0; bus.wb_sel_i = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // 1: single character and empty read
        feed(8'h1C);
        rd_expect("t1_csr_done", 1'b0, 16'h0080);
        rd_expect("t1_data_a", 1'b1, 16'h0061);
        rd_expect("t1_csr_empty", 1'b0, 16'h0000);
        rd_expect("t1_data_empty", 1'b1, 16'h0000);

        // 2: shift, then caps lock with typematic repeat
        do_reset();
        feed(8'h12); feed(8'h1C); feed(8'hF0); feed(8'h1C); feed(8'hF0); feed(8'h12); feed(8'h1C);
        rd_expect("t2_shift_A", 1'b1, 16'h0041);
        rd_expect("t2_plain_a", 1'b1, 16'h0061);
        feed(8'h58); feed(8'h58); feed(8'hF0); feed(8'h58); feed(8'h1C);
        rd_expect("t2_caps_A", 1'b1, 16'h0041);
        rd_expect("t2_empty", 1'b1, 16'h0000);

        // 3: overflow
        do_reset();
        repeat (9) feed(8'h1C);
        rd_expect("t3_csr_ovr", 1'b0, 16'h8080);
        rd_expect("t3_csr_ovr_clr", 1'b0, 16'h0080);

        // 4: interrupt
        do_reset();
        bus_xfer(1'b1, 1'b0, 16'h0040, d);
        feed(8'h5A);
        repeat (2) @(negedge clk);
        check("t4_irq_set", {15'b0, irq}, 16'h0001);
        iack = 1'b1;
        @(negedge clk);
        check("t4_irq_ack", {15'b0, irq}, 16'h0000);
        rd_expect("t4_data_cr", 1'b1, 16'h000D);
        iack = 1'b0;
        repeat (3) @(negedge clk);
        check("t4_irq_stays", {15'b0, irq}, 16'h0000);

        // 5: extended keys and reset mid-sequence
        do_reset();
        feed(8'hE0); feed(8'h75); feed(8'hE0); feed(8'hF0); feed(8'h75); feed(8'hE0); feed(8'h5A);
        rd_expect("t5_kp_enter", 1'b1, 16'h000D);
        rd_expect("t5_only_one", 1'b1, 16'h0000);
        feed(8'hE0);
        do_reset();
        feed(8'h1C);
        rd_expect("t5_after_rst", 1'b1, 16'h0061);

        // 6: ctrl and simultaneous push/pop at count 3
        do_reset();
        feed(8'h14); feed(8'h21);
`ifdef KBD_CTRL_EN
        rd_expect("t6_ctrl_c", 1'b1, 16'h0003);
`else
        rd_expect("t6_ctrl_c", 1'b1, 16'h0063);
`endif
        feed(8'hF0); feed(8'h14);
        repeat (3) feed(8'h1C);
        @(negedge clk);
        scan_valid = 1'b1; scan_data = 8'h32;
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0; bus.wb_adr_i = 16'h0002;
        @(negedge clk);
        scan_valid = 1'b0;
        check("t6_pp_ack", {15'b0, bus.wb_ack_o}, 16'h0001);
        check("t6_pp_data", bus.wb_dat_o, 16'h0061);
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
        rd_expect("t6_q1", 1'b1, 16'h0061);
        rd_expect("t6_q2", 1'b1, 16'h0061);
        rd_expect("t6_q3", 1'b1, 16'h0062);
        rd_expect("t6_q_empty", 1'b1, 16'h0000);

        // Randomized phase: every input re-drawn each cycle.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            logic go;
            @(negedge clk);
            rst = ($urandom_range(0, 199) == 0);
            iack = ($urandom_range(0, 7) == 0);
            scan_valid = ($urandom_range(0, 2) == 0);
            scan_data = ($urandom_range(0, 9) == 0) ? 8'($urandom) : pool[$urandom_range(0, 27)];
            go = ($urandom_range(0, 2) == 0);
            bus.wb_cyc_i = go;
            bus.wb_stb_i = go || ($urandom_range(0, 9) == 0);
            bus.wb_we_i = ($urandom_range(0, 3) == 0);
            bus.wb_adr_i = 16'($urandom);
            bus.wb_dat_i = 16'($urandom);
            bus.wb_sel_i = 2'($urandom);
        end
        @(negedge clk);
        rst = 1'b0; iack = 1'b0; scan_valid = 1'b0;
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
